oled_pixel_streamer: RTL and testbench



---
 rtl/oled_pkg.sv | 32 +++
 rtl/spi_byte_shifter.sv | 72 +++++++
 rtl/oled_pixel_streamer.sv | 189 ++++++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared panel geometry, SSD1331 window commands and streamer FSM encoding
package oled_pkg;

   localparam int OLED_W      = 96;
   localparam int OLED_H      = 64;
   localparam int OLED_PIXELS = OLED_W * OLED_H;

   localparam logic [7:0] CMD_SET_COL = 8'h15;
   localparam logic [7:0] CMD_SET_ROW = 8'h75;
   localparam int         N_CMD_BYTES = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_FETCH,
      ST_SHIFT,
      ST_NEXT
   } oled_state_e;

   // Full-panel address window: column 0..w-1, then row 0..h-1.
   function automatic logic [7:0] window_cmd(input logic [2:0] n, input int w, input int h);
      case (n)
         3'd0:    window_cmd = CMD_SET_COL;
         3'd1:    window_cmd = 8'h00;
         3'd2:    window_cmd = 8'(w - 1);
         3'd3:    window_cmd = CMD_SET_ROW;
         3'd4:    window_cmd = 8'h00;
         default: window_cmd = 8'(h - 1);
      endcase
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - MSB-first SPI mode-0 shifter, W bits per load, 2*CLK_DIV clks per bit
module spi_byte_shifter #(
   parameter int W       = 8,
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         sclk_o,
   output logic         mosi_o,
   output logic         done_o
);

   localparam int            DW       = $clog2(2 * CLK_DIV) + 1;
   localparam int            BW       = $clog2(W);
   localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

   logic [W-1:0]  sh_q, sh_d;
   logic [DW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          act_q, act_d;
   logic          sclk_q, sclk_d;

   assign mosi_o = sh_q[W-1];
   assign sclk_o = sclk_q;
   assign done_o = act_q && (div_q == DIV_LAST) && (bit_q == BIT_LAST);

   always_comb begin
      sh_d   = sh_q;
      div_d  = div_q;
      bit_d  = bit_q;
      act_d  = act_q;
      sclk_d = 1'b0;
      if (load_i) begin
         sh_d  = data_i;
         div_d = '0;
         bit_d = '0;
         act_d = 1'b1;
      end else if (act_q) begin
         // Shift only at the end of the high phase so mosi moves while sclk is low.
         if (div_q == DIV_LAST) begin
            div_d = '0;
            sh_d  = {sh_q[W-2:0], 1'b0};
            bit_d = bit_q + 1'b1;
            act_d = (bit_q != BIT_LAST);
         end else begin
            div_d  = div_q + 1'b1;
            sclk_d = (div_d >= DIV_HALF);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         div_q  <= '0;
         bit_q  <= '0;
         act_q  <= 1'b0;
         sclk_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         div_q  <= div_d;
         bit_q  <= bit_d;
         act_q  <= act_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/oled_pixel_streamer.sv
// rtl/oled_pixel_streamer.sv - scans the frame, fetches RGB565 per pixel and streams it over SPI
// OLED_WINDOW_CMD_EN: prefix every frame with the six-byte SSD1331 address-window command.
module oled_pixel_streamer
   import oled_pkg::*;
#(
   parameter int WIDTH   = OLED_W,
   parameter int HEIGHT  = OLED_H,
   parameter int CLK_DIV = 4,
   parameter int COL_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] oled_colour,
   output logic [12:0] pixel_index,
   output logic        frame_begin,
   output logic        busy,
   output logic        cs_n,
   output logic        sclk,
   output logic        mosi,
   output logic        dc
);

   localparam logic [12:0] PIX_LAST = 13'(WIDTH * HEIGHT - 1);
   localparam logic [1:0]  LAT_LAST = 2'(COL_LAT - 1);

   oled_state_e state_q, state_d;
   logic [12:0] idx_q, idx_d;
   logic [1:0]  lat_q, lat_d;
   logic        fb_q, fb_d;
   logic        busy_q, busy_d;
   logic        pix_load, pix_done, pix_sclk, pix_mosi;

   spi_byte_shifter #(.W(16), .CLK_DIV(CLK_DIV)) u_pix (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (pix_load),
      .data_i (oled_colour),
      .sclk_o (pix_sclk),
      .mosi_o (pix_mosi),
      .done_o (pix_done)
   );

   assign pixel_index = idx_q;
   assign frame_begin = fb_q;
   assign busy        = busy_q;
   assign cs_n        = ~busy_q;

`ifdef OLED_WINDOW_CMD_EN
   localparam logic [2:0] CMD_LAST = 3'(N_CMD_BYTES - 1);

   logic [2:0] cmd_n_q, cmd_n_d;
   logic       cmd_go_q, cmd_go_d;
   logic       dc_q, dc_d;
   logic       cmd_load, cmd_done, cmd_sclk, cmd_mosi;

   spi_byte_shifter #(.W(8), .CLK_DIV(CLK_DIV)) u_cmd (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (cmd_load),
      .data_i (window_cmd(cmd_n_q, WIDTH, HEIGHT)),
      .sclk_o (cmd_sclk),
      .mosi_o (cmd_mosi),
      .done_o (cmd_done)
   );

   // Both shifters drain to zero when idle, so OR-ing them is safe.
   assign sclk = pix_sclk | cmd_sclk;
   assign mosi = pix_mosi | cmd_mosi;
   assign dc   = dc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_n_q  <= '0;
         cmd_go_q <= 1'b0;
         dc_q     <= 1'b1;
      end else begin
         cmd_n_q  <= cmd_n_d;
         cmd_go_q <= cmd_go_d;
         dc_q     <= dc_d;
      end
   end
`else
   assign sclk = pix_sclk;
   assign mosi = pix_mosi;
   assign dc   = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lat_d    = lat_q;
      fb_d     = 1'b0;
      busy_d   = busy_q;
      pix_load = 1'b0;
`ifdef OLED_WINDOW_CMD_EN
      cmd_n_d  = cmd_n_q;
      cmd_go_d = 1'b0;
      dc_d     = dc_q;
      cmd_load = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               idx_d  = '0;
               lat_d  = '0;
               fb_d   = 1'b1;
               busy_d = 1'b1;
`ifdef OLED_WINDOW_CMD_EN
               state_d  = ST_CMD;
               cmd_n_d  = '0;
               cmd_go_d = 1'b1;
               dc_d     = 1'b0;
`else
               state_d = ST_FETCH;
`endif
            end
         end
`ifdef OLED_WINDOW_CMD_EN
         ST_CMD: begin
            if (cmd_go_q) begin
               cmd_load = 1'b1;
            end else if (cmd_done) begin
               if (cmd_n_q == CMD_LAST) begin
                  dc_d    = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  cmd_n_d  = cmd_n_q + 1'b1;
                  cmd_go_d = 1'b1;
               end
            end
         end
`endif
         // oled_colour is captured on the COL_LAT-th edge after pixel_index moved.
         ST_FETCH: begin
            if (lat_q == LAT_LAST) begin
               pix_load = 1'b1;
               state_d  = ST_SHIFT;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (pix_done) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            lat_d = '0;
            if (idx_q == PIX_LAST) begin
               idx_d = '0;
               if (enable) begin
                  fb_d = 1'b1;
`ifdef OLED_WINDOW_CMD_EN
                  state_d  = ST_CMD;
                  cmd_n_d  = '0;
                  cmd_go_d = 1'b1;
                  dc_d     = 1'b0;
`else
                  state_d = ST_FETCH;
`endif
               end else begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         lat_q   <= '0;
         fb_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         fb_q    <= fb_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// tb/tb_oled_pixel_streamer.sv - randomised bench checking the streamer against a frame-timeline model
module tb_oled_pixel_streamer;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int CD    = 2;
   localparam int CL    = 2;
   localparam int NPIX  = W * H;
   localparam int P     = CL + 1 + 32 * CD;
   localparam int FRAME = NPIX * P;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] oled_colour;
   logic [12:0] pixel_index;
   logic        frame_begin, busy, cs_n, sclk, mosi, dc;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] key = 16'h0;

   always #5 clk = ~clk;

   oled_pixel_streamer #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .CLK_DIV (CD),
      .COL_LAT (CL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .oled_colour (oled_colour),
      .pixel_index (pixel_index),
      .frame_begin (frame_begin),
      .busy        (busy),
      .cs_n        (cs_n),
      .sclk        (sclk),
      .mosi        (mosi),
      .dc          (dc)
   );

   function automatic logic [15:0] colour_of(input int idx);
      if (idx == 0) return 16'hF81F;
      return 16'(idx * 40503) ^ key;
   endfunction

   // Upstream colour path with COL_LAT=2: one register after pixel_index.
   logic [15:0] col_pipe;
   always @(posedge clk) col_pipe <= colour_of(int'(pixel_index));
   assign oled_colour = col_pipe;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is a fixed timeline of NPIX*P clks; only enable at the final clk decides continuation.
   bit m_act = 1'b0;
   int m_t = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 1'b0;
         m_t   <= 0;
      end else if (!m_act) begin
         if (enable) begin
            m_act <= 1'b1;
            m_t   <= 0;
         end
      end else if (m_t == FRAME - 1) begin
         if (enable) m_t <= 0;
         else m_act <= 1'b0;
      end else begin
         m_t <= m_t + 1;
      end
   end

   always @(negedge clk) begin : cmp
      int p, o, s;
      logic [15:0] word;
      if (!m_act) begin
         check("idle_index", 16'(pixel_index), 16'd0);
         check("idle_frame_begin", 16'(frame_begin), 16'd0);
         check("idle_busy", 16'(busy), 16'd0);
         check("idle_cs_n", 16'(cs_n), 16'd1);
         check("idle_sclk", 16'(sclk), 16'd0);
      end else begin
         p = m_t / P;
         o = m_t % P;
         s = o - CL;
         check("pixel_index", 16'(pixel_index), 16'(p));
         check("frame_begin", 16'(frame_begin), 16'(m_t == 0));
         check("busy", 16'(busy), 16'd1);
         check("cs_n", 16'(cs_n), 16'd0);
         if (s >= 0 && s < 32 * CD) begin
            word = colour_of(p);
            check("sclk_shift", 16'(sclk), 16'((s % (2 * CD)) >= CD));
            check("mosi", 16'(mosi), 16'(word[15 - s / (2 * CD)]));
         end else begin
            check("sclk_gap", 16'(sclk), 16'd0);
         end
      end
      check("dc", 16'(dc), 16'd1);
   end

   int          cyc = 0;
   int          fb_log[$];
   logic        prev_sclk = 1'b0;
   logic [15:0] first_word = 16'h0;
   int          nbits = 0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (frame_begin) fb_log.push_back(cyc);
      if (sclk && !prev_sclk && nbits < 16) begin
         first_word <= {first_word[14:0], mosi};
         nbits      <= nbits + 1;
      end
      prev_sclk <= sclk;
   end

   initial begin
      int waited, last_idx, n0;
      key = 16'($urandom);
      rst_n = 1'b0;
      enable = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Continuous streaming across two frame wraps.
      enable = 1'b1;
      repeat (2 * FRAME + 500) @(negedge clk);
      check("first_word", first_word, 16'hF81F);
      check("frames_started", 16'(fb_log.size()), 16'd3);
      if (fb_log.size() >= 2) check("frame_period", 16'(fb_log[1] - fb_log[0]), 16'd2144);

      // Drop enable at pixel 20: the frame must still finish.
      waited = 0;
      while (pixel_index != 13'd20 && waited < 2 * FRAME) begin
         @(negedge clk);
         waited++;
      end
      check("reach_pixel20", 16'(waited < 2 * FRAME), 16'd1);
      enable = 1'b0;
      n0 = fb_log.size();
      waited = 0;
      last_idx = 0;
      while (busy && waited < FRAME) begin
         last_idx = int'(pixel_index);
         @(negedge clk);
         waited++;
      end
      check("drop_last_index", 16'(last_idx), 16'd31);
      check("drop_tail_cycles", 16'(waited), 16'd804);
      repeat (300) @(negedge clk);
      check("drop_no_new_frame", 16'(fb_log.size() - n0), 16'd0);
      check("drop_cs_n", 16'(cs_n), 16'd1);

      // Random enable activity, including toggles around frame ends.
      repeat (40) begin
         enable = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 150)) @(negedge clk);
      end

      // Asynchronous reset in the middle of a word.
      enable = 1'b1;
      repeat ($urandom_range(0, FRAME)) @(negedge clk);
      waited = 0;
      while (!(sclk && busy) && waited < FRAME) begin
         @(negedge clk);
         waited++;
      end
      check("reach_shift", 16'(waited < FRAME), 16'd1);
      enable = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_cs_n", 16'(cs_n), 16'd1);
      check("rst_sclk", 16'(sclk), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_index", 16'(pixel_index), 16'd0);
      check("rst_mosi", 16'(mosi), 16'd0);
      check("rst_frame_begin", 16'(frame_begin), 16'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
